// File: rtl/ram_pkg.sv
// Shared constants for the byte-enable dual-port RAM: read-during-write
// policy codes and the init/run state encoding.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result delay line: LATENCY stages of valid/data, cleared by reset so
// that reads in flight when reset hits never produce a result.
module ram_rd_pipe #(
  parameter int LATENCY    = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]    valid_q;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];

  // Data stages only load when their valid does, so the last stage holds
  // the most recent result between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int k = 1; k < LATENCY; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with per-byte write enables, self-initialisation after
// reset and a configurable read latency / read-during-write policy.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RD_LATENCY = 1,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      init_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  ram_state_e            state_q;
  ram_state_e            state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  init_we;
  logic                  user_we;
  logic                  user_rd;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rdw_bypass;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_addr_q == {ADDR_WIDTH{1'b1}}) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Reset also masks the array ports so nothing is written or read on the
  // edge that restarts initialisation.
  always_comb begin
    init_busy = 1'b0;
    init_we   = 1'b0;
    user_we   = 1'b0;
    user_rd   = 1'b0;
    case (state_q)
      INIT: begin
        init_busy = 1'b1;
        init_we   = !rst;
      end
      RUN: begin
        user_we = wr_en && !rst;
        user_rd = rd_en && !rst;
      end
      default: init_busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_addr_q <= '0;
    end else if (state_q == INIT) begin
      init_addr_q <= init_addr_q + 1'b1;
    end
  end

  // Array has no reset; contents are cleared only by the init sweep.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr_q] <= INIT_VALUE;
    end else if (user_we) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign old_word = mem[rd_addr];

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        merged_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  assign rdw_bypass = (RDW_MODE == RDW_WRITE_FIRST) && user_we && (wr_addr == rd_addr);
  assign rd_word    = rdw_bypass ? merged_word : old_word;

  ram_rd_pipe #(
    .LATENCY    (RD_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (user_rd),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

endmodule

// File: doc/ram_dp_be.md
RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, address bits; DEPTH = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word bits; multiple of 8; NB = DATA_WIDTH/8 byte lanes.
REQ-003 SHALL have parameter RD_LATENCY, default 1, legal values 1 or 2; cycles from read request to data.
REQ-004 SHALL have parameter RDW_MODE, default 0, same-address read-during-write policy: 0 = READ_FIRST, 1 = WRITE_FIRST.
REQ-005 SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH-bit value written to every word by the init sequence.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 wr_en  input  1  write request, sampled each cycle.
REQ-009 wr_addr  input  ADDR_WIDTH  write word address.
REQ-010 wr_data  input  DATA_WIDTH  write data.
REQ-011 wr_be  input  NB  byte enables; bit i selects wr_data[8i+7:8i].
REQ-012 rd_en  input  1  read request, sampled each cycle.
REQ-013 rd_addr  input  ADDR_WIDTH  read word address.
REQ-014 rd_data  output  DATA_WIDTH  registered read data.
REQ-015 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-016 init_busy  output  1  high while memory initialisation is in progress.

Function
REQ-017 SHALL implement a two-state FSM: INIT and RUN; state INIT after reset.
REQ-018 In INIT, SHALL write INIT_VALUE to one address per cycle from 0 to DEPTH-1 via an ADDR_WIDTH-bit counter; on the cycle writing DEPTH-1, SHALL transition to RUN; INIT lasts exactly DEPTH cycles after rst deasserts.
REQ-019 init_busy SHALL equal 1 in INIT, 0 in RUN.
REQ-020 In INIT, wr_en and rd_en SHALL be ignored; no user write, no rd_valid.
REQ-021 In RUN, wr_en=1 SHALL update only lanes with wr_be[i]=1 at wr_addr; wr_be all-zero SHALL leave memory unchanged.
REQ-022 In RUN, rd_en=1 at cycle T SHALL give rd_valid=1 and rd_data = word at rd_addr at cycle T+RD_LATENCY; back-to-back reads SHALL sustain one result per cycle.
REQ-023 rd_data SHALL hold its last value when rd_valid=0.
REQ-024 Simultaneous wr_en and rd_en to different addresses SHALL both complete with no interaction.
REQ-025 Same address, RDW_MODE=0: read SHALL return the pre-write word.
REQ-026 Same address, RDW_MODE=1: read SHALL return the merged word (enabled lanes from wr_data, others from old word).
REQ-027 Read issued the cycle after a write to the same address SHALL return the written data in both modes.
REQ-028 Addresses SHALL be full-range; no wrap or out-of-range case exists (DEPTH = 2**ADDR_WIDTH).
REQ-029 Requests pending in the read pipeline when rst asserts SHALL be discarded; no rd_valid for them.

Reset
REQ-030 rst=1 at a rising edge SHALL set: state INIT, init counter 0, rd_valid 0 (incl. pipeline stages), rd_data 0, init_busy 1.
REQ-031 rst asserted mid-INIT SHALL restart initialisation from address 0.
REQ-032 rst SHALL not be required to clear array contents directly; clearing occurs only via INIT.

Structure
REQ-033 Package ram_pkg SHALL hold RDW mode constants (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1) and FSM state encoding (INIT, RUN).
REQ-034 Read pipeline SHALL be one sub-module ram_rd_pipe (RD_LATENCY-deep valid/data delay, reset-clearable); array, FSM and byte merge stay in ram_dp_be.

Verification
REQ-035 Reset then 20 idle cycles, ADDR_WIDTH=4 -> init_busy=1 for exactly 16 cycles after rst low; read all 16 addresses -> 0x00000000.
REQ-036 Write addr 3 data 0xAABBCCDD be 0xF, then addr 3 data 0x11223344 be 0x5; read addr 3 -> 0xAA22CC44, rd_valid exactly RD_LATENCY cycles after rd_en (run for RD_LATENCY=1 and 2).
REQ-037 Addr 5 holds 0x12345678; same cycle write 0xFFFFFFFF be 0x3 and read addr 5 -> RDW_MODE=0 returns 0x12345678, RDW_MODE=1 returns 0x1234FFFF.
REQ-038 wr_en/rd_en asserted during INIT with data 0xDEADBEEF to addr 7 -> no rd_valid; after INIT, read addr 7 -> 0x00000000.
REQ-039 rst pulsed at cycle 8 of INIT after writing nothing, and again with a read in flight -> init restarts at 0 (busy 16 more cycles), in-flight read produces no rd_valid.
